// File: rtl/quadro_peso_pkg.sv
`default_nettype none
// ============================================================================
// Module : quadro_peso_pkg
// Brief  : Shared constants, state type and helpers for the weight-frame parser.
// Rev    : 1.0 - initial release
// ============================================================================
package quadro_peso_pkg;

  localparam logic [7:0] ASCII_INICIO = 8'h23;
  localparam logic [7:0] ASCII_FIM    = 8'h3B;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    DADOS  = 2'd1,
    FIM    = 2'd2
  } estado_t;

  function automatic logic ehDigito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= 8'h39);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timeout_quadro.sv
`default_nettype none
// ============================================================================
// Module : timeout_quadro
// Brief  : Inter-byte idle counter; flags expiry after TIMEOUT_CICLOS idle clocks.
// Rev    : 1.0 - initial release
// ============================================================================
module timeout_quadro #(
  parameter int TIMEOUT_CICLOS = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] r_contagem;

  // Holds at the limit; the parser leaves the frame on the next edge, which clears it.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_contagem <= '0;
    end else if (conta && (r_contagem != LIMITE)) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  assign fim = conta && (r_contagem == LIMITE);

endmodule
`default_nettype wire

// File: rtl/recepcao_quadro_peso.sv
`default_nettype none
// ============================================================================
// Module : recepcao_quadro_peso
// Brief  : Parses "#<max><min><atual>;" ASCII frames into packed-BCD weight
//          fields, updated atomically per good frame. Optional inter-byte
//          timeout is built when FRAME_TIMEOUT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module recepcao_quadro_peso
  import quadro_peso_pkg::*;
#(
  parameter int N_DIGITOS      = 4,
  parameter int TIMEOUT_CICLOS = 5_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             rx_dado,
  input  logic                   rx_valido,
  output logic [4*N_DIGITOS-1:0] peso_max,
  output logic [4*N_DIGITOS-1:0] peso_min,
  output logic [4*N_DIGITOS-1:0] peso_atual,
  output logic                   quadro_pronto,
  output logic                   erro_quadro,
  output logic                   ocupado,
  output logic [3:0]             db_erros,
  output logic [1:0]             db_estado
);

  localparam int TOTAL = 3 * N_DIGITOS;
  localparam int LARG  = 4 * N_DIGITOS;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(TOTAL - 1);

  estado_t            r_estado, w_estadoProx;
  logic [4*TOTAL-1:0] r_staging, w_stagingProx;
  logic [IDX_W-1:0]   r_indice, w_indiceProx;
  logic               w_ok, w_erro, w_timeout;

`ifdef FRAME_TIMEOUT_EN
  timeout_quadro #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (rx_valido || (r_estado == OCIOSO)),
    .conta (r_estado != OCIOSO),
    .fim   (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_estadoProx  = r_estado;
    w_stagingProx = r_staging;
    w_indiceProx  = r_indice;
    w_ok          = 1'b0;
    w_erro        = 1'b0;
    if (rx_valido) begin
      if (rx_dado == ASCII_INICIO) begin
        w_erro        = (r_estado != OCIOSO);
        w_estadoProx  = DADOS;
        w_stagingProx = '0;
        w_indiceProx  = '0;
      end else begin
        case (r_estado)
          OCIOSO: ;
          DADOS: begin
            if (ehDigito(rx_dado)) begin
              // Low nibble of an ASCII digit equals (byte - '0').
              w_stagingProx = {r_staging[4*TOTAL-5:0], rx_dado[3:0]};
              w_indiceProx  = r_indice + 1'b1;
              if (r_indice == ULTIMO) w_estadoProx = FIM;
            end else begin
              w_erro        = 1'b1;
              w_estadoProx  = OCIOSO;
              w_stagingProx = '0;
              w_indiceProx  = '0;
            end
          end
          FIM: begin
            w_ok          = (rx_dado == ASCII_FIM);
            w_erro        = (rx_dado != ASCII_FIM);
            w_estadoProx  = OCIOSO;
            w_stagingProx = '0;
            w_indiceProx  = '0;
          end
          default: w_estadoProx = OCIOSO;
        endcase
      end
    end else if (w_timeout) begin
      w_erro        = 1'b1;
      w_estadoProx  = OCIOSO;
      w_stagingProx = '0;
      w_indiceProx  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado      <= OCIOSO;
      r_staging     <= '0;
      r_indice      <= '0;
      peso_max      <= '0;
      peso_min      <= '0;
      peso_atual    <= '0;
      quadro_pronto <= 1'b0;
      erro_quadro   <= 1'b0;
      ocupado       <= 1'b0;
      db_erros      <= 4'd0;
    end else begin
      r_estado      <= w_estadoProx;
      r_staging     <= w_stagingProx;
      r_indice      <= w_indiceProx;
      quadro_pronto <= w_ok;
      erro_quadro   <= w_erro;
      ocupado       <= (w_estadoProx != OCIOSO);
      if (w_ok) begin
        peso_max   <= r_staging[3*LARG-1 -: LARG];
        peso_min   <= r_staging[2*LARG-1 -: LARG];
        peso_atual <= r_staging[LARG-1:0];
      end
      if (w_erro && (db_erros != 4'd15)) db_erros <= db_erros + 4'd1;
    end
  end

  assign db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_recepcao_quadro_peso.sv
`default_nettype none
// ============================================================================
// Module : tb_recepcao_quadro_peso
// Brief  : Self-checking bench with a queue-based frame reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_recepcao_quadro_peso;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_dado;
  logic        rx_valido;
  logic [15:0] peso_max, peso_min, peso_atual;
  logic        quadro_pronto, erro_quadro, ocupado;
  logic [3:0]  db_erros;
  logic [1:0]  db_estado;

  int checks = 0;
  int errors = 0;

  recepcao_quadro_peso #(
    .N_DIGITOS      (4),
    .TIMEOUT_CICLOS (100)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_dado       (rx_dado),
    .rx_valido     (rx_valido),
    .peso_max      (peso_max),
    .peso_min      (peso_min),
    .peso_atual    (peso_atual),
    .quadro_pronto (quadro_pronto),
    .erro_quadro   (erro_quadro),
    .ocupado       (ocupado),
    .db_erros      (db_erros),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  // Reference model: a frame is '#', 12 digits collected in a queue, then ';'.
  bit          mAtivo;
  int          mDig[$];
  logic [15:0] mMax, mMin, mAtual;
  int          mErros;
  bit          expOk, expErr;

  function automatic logic [15:0] campo(input int f);
    logic [15:0] v = 16'd0;
    for (int i = 0; i < 4; i++) v = v * 16 + 16'(mDig[f*4+i]);
    return v;
  endfunction

  function automatic logic [1:0] expEstado();
    if (!mAtivo) return 2'd0;
    return (mDig.size() == 12) ? 2'd2 : 2'd1;
  endfunction

  task automatic modeloErro();
    expErr = 1'b1;
    if (mErros < 15) mErros++;
  endtask

  task automatic modelo(input logic [7:0] b);
    if (b == 8'h23) begin
      if (mAtivo) modeloErro();
      mAtivo = 1'b1;
      mDig.delete();
    end else if (mAtivo) begin
      if (mDig.size() < 12) begin
        if (b >= 8'h30 && b <= 8'h39) mDig.push_back(int'(b) - 48);
        else begin modeloErro(); mAtivo = 1'b0; end
      end else begin
        if (b == 8'h3B) begin
          expOk = 1'b1;
          mMax = campo(0); mMin = campo(1); mAtual = campo(2);
        end else modeloErro();
        mAtivo = 1'b0;
      end
    end
  endtask

  // Drives one cycle at a negedge, advances the model, returns at the next negedge.
  task automatic apply(input bit v, input logic [7:0] b);
    rx_valido = v;
    rx_dado   = v ? b : 8'($urandom);
    expOk     = 1'b0;
    expErr    = 1'b0;
    if (v) modelo(b);
    @(negedge clock);
    rx_valido = 1'b0;
  endtask

  task automatic doReset(input bit withByte);
    reset     = 1'b1;
    rx_valido = withByte;
    rx_dado   = 8'h23;
    @(negedge clock);
    rx_valido = 1'b0;
    @(negedge clock);
    reset  = 1'b0;
    mAtivo = 1'b0; mDig.delete();
    mMax = 0; mMin = 0; mAtual = 0; mErros = 0;
    expOk = 1'b0; expErr = 1'b0;
  endtask

  task automatic test_reset();
    doReset(1'b1);
    checks++;
    if ({peso_max, peso_min, peso_atual, quadro_pronto, erro_quadro, ocupado, db_erros, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h/%h/%h ok=%b err=%b ocup=%b erros=%0d est=%0d, want all zero",
               peso_max, peso_min, peso_atual, quadro_pronto, erro_quadro, ocupado, db_erros, db_estado);
    end
    apply(1'b0, 8'h00);
    checks++;
    if (db_estado !== 2'd0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_byte: est=%0d ocup=%b, want est=0 ocup=0", db_estado, ocupado);
    end
  endtask

  task automatic test_good_frame();
    string s = "#075001201000;";
    int nOk = 0;
    for (int i = 0; i < s.len(); i++) begin
      apply(1'b1, s[i]);
      nOk += int'(quadro_pronto);
      checks++;
      if (quadro_pronto !== expOk || erro_quadro !== expErr) begin
        errors++;
        $display("FAIL good_pulses[%0d]: ok=%b err=%b, want ok=%b err=%b", i, quadro_pronto, erro_quadro, expOk, expErr);
      end
    end
    apply(1'b0, 8'h00);
    nOk += int'(quadro_pronto);
    checks++;
    if (peso_max !== 16'h0750 || peso_min !== 16'h0120 || peso_atual !== 16'h1000 || nOk != 1) begin
      errors++;
      $display("FAIL good_fields: %h/%h/%h pulses=%0d, want 0750/0120/1000 pulses=1", peso_max, peso_min, peso_atual, nOk);
    end
  endtask

  task automatic test_bad_digit();
    string s = "#07A";
    for (int i = 0; i < s.len(); i++) apply(1'b1, s[i]);
    checks++;
    if (erro_quadro !== 1'b1 || db_estado !== 2'd0 || db_erros !== 4'd1 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL bad_digit: err=%b est=%0d erros=%0d ocup=%b, want err=1 est=0 erros=1 ocup=0",
               erro_quadro, db_estado, db_erros, ocupado);
    end
    checks++;
    if (peso_max !== 16'h0750 || peso_min !== 16'h0120 || peso_atual !== 16'h1000) begin
      errors++;
      $display("FAIL bad_digit_hold: %h/%h/%h, want 0750/0120/1000", peso_max, peso_min, peso_atual);
    end
  endtask

  task automatic test_restart();
    string s = "#0750#999900000500;";
    int nOk = 0, nErr = 0, errAt = -1;
    for (int i = 0; i < s.len(); i++) begin
      apply(1'b1, s[i]);
      nOk += int'(quadro_pronto);
      nErr += int'(erro_quadro);
      if (erro_quadro === 1'b1 && errAt < 0) errAt = i;
    end
    checks++;
    if (nErr != 1 || errAt != 5 || nOk != 1 || quadro_pronto !== 1'b1) begin
      errors++;
      $display("FAIL restart_pulses: errs=%0d at %0d oks=%0d, want errs=1 at 5 oks=1 on last byte", nErr, errAt, nOk);
    end
    checks++;
    if (peso_max !== 16'h9999 || peso_min !== 16'h0000 || peso_atual !== 16'h0500 || db_erros !== 4'd2) begin
      errors++;
      $display("FAIL restart_fields: %h/%h/%h erros=%0d, want 9999/0000/0500 erros=2", peso_max, peso_min, peso_atual, db_erros);
    end
  endtask

  task automatic test_timeout();
    int first = 0, nErr = 0;
    doReset(1'b0);
    apply(1'b1, 8'h23);
    apply(1'b1, 8'h30);
    for (int k = 1; k <= 150; k++) begin
      apply(1'b0, 8'h00);
      if (erro_quadro === 1'b1) begin
        nErr++;
        if (first == 0) first = k;
      end
    end
`ifdef FRAME_TIMEOUT_EN
    checks++;
    if (first != 100 || nErr != 1 || ocupado !== 1'b0 || db_erros !== 4'd1) begin
      errors++;
      $display("FAIL timeout: first=%0d errs=%0d ocup=%b erros=%0d, want first=100 errs=1 ocup=0 erros=1",
               first, nErr, ocupado, db_erros);
    end
    mAtivo = 1'b0; mErros = 1;
    // A byte arriving exactly at expiry must win over the timeout.
    apply(1'b1, 8'h23);
    for (int k = 1; k <= 99; k++) apply(1'b0, 8'h00);
    apply(1'b1, 8'h31);
    checks++;
    if (erro_quadro !== 1'b0 || ocupado !== 1'b1 || db_estado !== 2'd1) begin
      errors++;
      $display("FAIL timeout_byte_wins: err=%b ocup=%b est=%0d, want err=0 ocup=1 est=1", erro_quadro, ocupado, db_estado);
    end
`else
    checks++;
    if (nErr != 0 || ocupado !== 1'b1 || db_estado !== 2'd1) begin
      errors++;
      $display("FAIL no_timeout: errs=%0d ocup=%b est=%0d, want errs=0 ocup=1 est=1", nErr, ocupado, db_estado);
    end
`endif
    doReset(1'b0);
  endtask

  task automatic test_reset_mid();
    string a = "#0750";
    string b = "#123456789012;";
    for (int i = 0; i < a.len(); i++) apply(1'b1, a[i]);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({peso_max, peso_min, peso_atual} !== '0 || erro_quadro !== 1'b0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: %h/%h/%h err=%b ocup=%b, want 0/0/0 err=0 ocup=0",
               peso_max, peso_min, peso_atual, erro_quadro, ocupado);
    end
    doReset(1'b0);
    for (int i = 0; i < b.len(); i++) apply(1'b1, b[i]);
    checks++;
    if (peso_max !== 16'h1234 || peso_min !== 16'h5678 || peso_atual !== 16'h9012 || quadro_pronto !== 1'b1 || db_erros !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_recover: %h/%h/%h ok=%b erros=%0d, want 1234/5678/9012 ok=1 erros=0",
               peso_max, peso_min, peso_atual, quadro_pronto, db_erros);
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 20; f++) begin
      apply(1'b1, 8'h23);
      apply(1'b1, 8'h35);
      apply(1'b1, 8'h58);
      checks++;
      if (erro_quadro !== 1'b1 || db_erros !== 4'(mErros)) begin
        errors++;
        $display("FAIL saturation[%0d]: err=%b erros=%0d, want err=1 erros=%0d", f, erro_quadro, db_erros, mErros);
      end
    end
    checks++;
    if (db_erros !== 4'd15) begin
      errors++;
      $display("FAIL saturation_final: erros=%0d, want 15", db_erros);
    end
  endtask

  task automatic test_noise();
    logic [7:0] b;
    int nPulse = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if (b == 8'h23) b = 8'h3B;
      apply(1'b1, b);
      nPulse += int'(quadro_pronto) + int'(erro_quadro);
      if (db_estado !== 2'd0) nPulse++;
    end
    checks++;
    if (nPulse != 0 || db_erros !== 4'd15) begin
      errors++;
      $display("FAIL noise: pulses/state-changes=%0d erros=%0d, want 0 and 15", nPulse, db_erros);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] fr[14];
    doReset(1'b0);
    for (int f = 0; f < 40; f++) begin
      fr[0] = 8'h23;
      for (int i = 1; i <= 12; i++) fr[i] = 8'(8'h30 + $urandom_range(0, 9));
      fr[13] = 8'h3B;
      if ($urandom_range(0, 3) == 0) fr[$urandom_range(1, 13)] = 8'($urandom);
      for (int i = 0; i < 14; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          apply(1'b0, 8'h00);
          checks++;
          if (quadro_pronto !== 1'b0 || erro_quadro !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle: ok=%b err=%b, want 0 0", quadro_pronto, erro_quadro);
          end
        end
        apply(1'b1, fr[i]);
        checks++;
        if (quadro_pronto !== expOk || erro_quadro !== expErr) begin
          errors++;
          $display("FAIL rand_pulses f%0d b%0d: ok=%b err=%b, want ok=%b err=%b", f, i, quadro_pronto, erro_quadro, expOk, expErr);
        end
        checks++;
        if (peso_max !== mMax || peso_min !== mMin || peso_atual !== mAtual) begin
          errors++;
          $display("FAIL rand_fields f%0d b%0d: %h/%h/%h, want %h/%h/%h", f, i, peso_max, peso_min, peso_atual, mMax, mMin, mAtual);
        end
        checks++;
        if (db_erros !== 4'(mErros) || ocupado !== mAtivo || db_estado !== expEstado()) begin
          errors++;
          $display("FAIL rand_status f%0d b%0d: erros=%0d ocup=%b est=%0d, want %0d %b %0d",
                   f, i, db_erros, ocupado, db_estado, mErros, mAtivo, expEstado());
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    rx_valido = 1'b0;
    rx_dado   = 8'h00;
    @(negedge clock);
    test_reset();
    test_good_frame();
    test_bad_digit();
    test_restart();
    test_timeout();
    test_reset_mid();
    test_saturation();
    test_noise();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
